// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply / 32/32 divide unit with HI/LO
// result registers. One operation at a time: PREP (1) + RUN (32) + FIX (1).
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_EX,
    input  logic        Op_EX,
    input  logic        Signed_EX,
    input  logic [31:0] SrcA_EX,
    input  logic [31:0] SrcB_EX,
    input  logic        Flush,
    input  logic        MfReq_ID,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic        MdStall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic        op_q;
    logic        sgn_q;
    logic        neg_res;
    logic        neg_rem;
    logic        bzero;
    logic [31:0] a_orig;
    logic [31:0] b_reg;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic        accept;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_abs;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Issue acceptance and pipeline stall request
    always_comb begin
        accept  = Start_EX & ~Flush & (state == S_IDLE);
        MdStall = (MfReq_ID & (Busy | accept)) | (Start_EX & Busy);
    end

    // Per-iteration datapath and final sign correction
    always_comb begin
        a_abs     = (sgn_q & a_orig[31]) ? -a_orig : a_orig;
        b_abs     = (sgn_q & b_reg[31])  ? -b_reg  : b_reg;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, b_reg};
        // remainder < divisor keeps a non-negative difference below 2^32,
        // so bit 32 doubles as the borrow
        div_ge    = ~div_diff[32];
        prod_abs  = {acc_hi, acc_lo};
        prod_fix  = neg_res ? -prod_abs : prod_abs;
        q_fix     = neg_res ? -acc_lo : acc_lo;
        r_fix     = neg_rem ? -acc_hi : acc_hi;
    end

    // Control FSM, operand/accumulator registers and HI/LO result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= 1'b0;
            sgn_q   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bzero   <= 1'b0;
            a_orig  <= '0;
            b_reg   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            Hi      <= '0;
            Lo      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_q   <= Op_EX;
                            sgn_q  <= Signed_EX;
                            a_orig <= SrcA_EX;
                            b_reg  <= SrcB_EX;
                            bzero  <= (SrcB_EX == '0);
                            Busy   <= 1'b1;
                            state  <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        acc_hi  <= '0;
                        acc_lo  <= a_abs;
                        b_reg   <= b_abs;
                        neg_res <= sgn_q & (a_orig[31] ^ b_reg[31]);
                        neg_rem <= sgn_q & a_orig[31];
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        if (op_q) begin
                            acc_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                            acc_lo <= {acc_lo[30:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[32:1];
                            acc_lo <= {mul_sum[0], acc_lo[31:1]};
                        end
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (!op_q) begin
                            Hi <= prod_fix[63:32];
                            Lo <= prod_fix[31:0];
                        end else if (bzero) begin
                            Hi <= a_orig;
                            Lo <= '1;
                        end else begin
                            Hi <= r_fix;
                            Lo <= q_fix;
                        end
                        DivZero <= op_q & bzero;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
